// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for one shared W-bit D-flop register.
// Grants one requester at a time and commits its data one cycle after the grant.
module dff_bank_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wr_data,
  input  logic             clr,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic             busy,
  output logic [W-1:0]     q,
  output logic [W-1:0]     q_bar
);

  // state | meaning
  // IDLE  | no grant outstanding; pick next winner round-robin from ptr
  // GRANT | one-cycle grant; commit winner's data unless it dropped req

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]   N_EXT = (PW+1)'(N);
  localparam logic [PW-1:0] LAST  = PW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  q_q, q_d;

  logic [PW:0]   idx;
  logic [PW-1:0] pick;
  logic          found;
  logic [W-1:0]  sel_data;

  // First set request bit at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_q == PW'(i)) sel_data = wr_data[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    ack_d   = '0;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = N'(1) << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req[win_q]) begin
          q_d   = sel_data;
          ack_d = gnt_q;
          ptr_d = (win_q == LAST) ? '0 : win_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear wins over a same-edge commit; ack and ptr still advance.
    if (clr) q_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign busy  = (state_q == GRANT);
  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (N=4, W=8) with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wr_data;
  logic        clr;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  q_bar;

  int n_chk  = 0;
  int n_pass = 0;

  dff_bank_arbiter #(.N(4), .W(8)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr_data (wr_data),
    .clr     (clr),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy),
    .q       (q),
    .q_bar   (q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] dat [4];
  int         order [5];
  logic [3:0] oh;

  initial begin
    rst = 1'b0; req = '0; wr_data = '0; clr = 1'b0;
    order = '{0, 1, 2, 3, 0};

    // reset held for three cycles
    repeat (3) tick();
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", q_bar, 8'hFF);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;

    // single request from requester 2
    req = 4'b0100; wr_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    chk("t2_gnt", gnt, 4'b0100);
    chk("t2_busy", busy, 1'b1);
    chk("t2_ack_not_with_gnt", ack, 4'b0000);
    tick();
    chk("t2_q", q, 8'hA5);
    chk("t2_qbar", q_bar, 8'h5A);
    chk("t2_ack", ack, 4'b0100);
    chk("t2_gnt_off", gnt, 4'b0000);
    req = 4'b0000;
    tick();
    chk("t2_ack_pulse", ack, 4'b0000);

    // ptr is 3: wrap from 3 to 0
    req = 4'b1001; wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    chk("t4_gnt3", gnt, 4'b1000);
    tick();
    chk("t4_ack3", ack, 4'b1000);
    chk("t4_q3", q, 8'h44);
    tick();
    chk("t4_gnt0", gnt, 4'b0001);
    tick();
    chk("t4_ack0", ack, 4'b0001);
    chk("t4_q0", q, 8'h11);
    req = 4'b0001; wr_data = {8'h44, 8'h33, 8'h22, 8'h55};
    tick();
    chk("t4_gnt0_only", gnt, 4'b0001);
    tick();
    chk("t4_q0_only", q, 8'h55);
    req = 4'b0000;
    tick();

    // reset pulse to return ptr to 0
    rst = 1'b0;
    #1;
    chk("rst2_q", q, 8'h00);
    tick();
    rst = 1'b1;

    // all four requesting: round-robin 0,1,2,3,0
    dat = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    wr_data = {dat[3], dat[2], dat[1], dat[0]};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      oh = 4'b0001 << order[n];
      tick();
      chk($sformatf("t3_gnt%0d", n), gnt, oh);
      chk($sformatf("t3_ack_idle%0d", n), ack, 4'b0000);
      tick();
      chk($sformatf("t3_ack%0d", n), ack, oh);
      chk($sformatf("t3_q%0d", n), q, dat[order[n]]);
      chk($sformatf("t3_busy%0d", n), busy, 1'b0);
    end
    req = 4'b0000;
    tick();

    // ptr is 1: requester 1 aborts in its GRANT cycle
    req = 4'b0010;
    tick();
    chk("t5_gnt1", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    chk("t5_abort_ack", ack, 4'b0000);
    chk("t5_abort_q", q, 8'hA0);
    chk("t5_abort_busy", busy, 1'b0);
    req = 4'b1111;
    tick();
    chk("t5_regrant1", gnt, 4'b0010);
    tick();
    chk("t5_ack1", ack, 4'b0010);
    chk("t5_q1", q, 8'hB1);
    req = 4'b0000;
    tick();

    // clear on the commit edge of requester 2
    req = 4'b0100; wr_data = {8'h00, 8'h3C, 8'h00, 8'h00};
    tick();
    chk("t6_gnt2", gnt, 4'b0100);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr_q", q, 8'h00);
    chk("t6_clr_qbar", q_bar, 8'hFF);
    chk("t6_clr_ack", ack, 4'b0100);
    req = 4'b0000;
    tick();

    // ptr is 3 after the cleared commit; write 0x77 from requester 3
    req = 4'b1000; wr_data = {8'h77, 8'h00, 8'h00, 8'h00};
    tick();
    chk("t6_gnt3_ptr", gnt, 4'b1000);
    tick();
    chk("t6_q3", q, 8'h77);
    req = 4'b0001; wr_data = {8'h77, 8'h00, 8'h00, 8'h99};
    tick();
    chk("t6_gnt0", gnt, 4'b0001);
    chk("t6_busy", busy, 1'b1);
    // asynchronous reset in the middle of GRANT
    rst = 1'b0;
    #1;
    chk("t6_arst_gnt", gnt, 4'b0000);
    chk("t6_arst_busy", busy, 1'b0);
    chk("t6_arst_q", q, 8'h00);
    chk("t6_arst_qbar", q_bar, 8'hFF);
    tick();
    chk("t6_arst_lost_write", q, 8'h00);
    chk("t6_arst_ack", ack, 4'b0000);
    req = 4'b0000;
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
